btb_next_pc: RTL and testbench
==============================

// Module: btb_next_pc
// PURPOSE
//  Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB), feeding the gshare predictor.
//  Drives the fetch PC and its low bits (branch address). Combines the gshare taken/not-taken prediction with
//  the BTB target. Resolves EX/MEM branch outcomes: writes the BTB, detects mispredicts and issues a flush window.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded at reset
//  BTB_IDX_BITS  6              BTB has 2**BTB_IDX_BITS entries
//  FLUSH_CYCLES  2              cycles flush stays high after a redirect (1..15)
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   reset, asynchronous, active-high
//  stall           in   1   hold PC (hazard); ignored when a redirect occurs
//  pred_taken      in   1   gshare prediction for current pc
//  upd_valid       in   1   EX/MEM branch/jump resolved this cycle
//  upd_pc          in   32  PC of the resolved instruction
//  upd_taken       in   1   actual outcome
//  upd_target      in   32  actual taken target
//  upd_pred_taken  in   1   prediction made for it at fetch
//  upd_pred_target in   32  target fetched after it when predicted taken
//  pc              out  32  current fetch PC
//  btb_hit         out  1   valid entry with matching tag for pc
//  pred_target     out  32  BTB target for pc (0 when !btb_hit)
//  flush           out  1   kill IF/ID and ID/EX contents
//  mispredict      out  1   combinational: mispredict detected this cycle
// BEHAVIOUR
//  Reset: pc=RESET_PC, all BTB valid=0, flush=0, FSM=RUN, counters=0. Takes effect immediately, mid-operation included.
//  Indexing: idx = pc[BTB_IDX_BITS+1:2]; tag = pc[31:BTB_IDX_BITS+2]. Same split applies to upd_pc.
//  Lookup: combinational on pc. btb_hit = valid[idx] && tag match.
//  Mispredict: mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_pred_target != upd_target)).
//  Correct PC: fix_pc = upd_taken ? upd_target : upd_pc+4.
//  Next PC priority, registered on posedge:
//   (1) mispredict      -> pc <= fix_pc, even when stall=1
//   (2) stall           -> hold
//   (3) FSM=RUN && pred_taken && btb_hit -> pred_target
//   (4) otherwise       -> pc+4, wraps modulo 2**32
//  A predicted-taken PC with a BTB miss falls through to pc+4. The later resolution then mispredicts on target.
//  BTB write: on upd_valid && upd_taken, write {valid=1, tag, upd_target} at upd_pc's idx (overwrite on conflict).
//  Not-taken updates leave the entry unchanged. A same-cycle read and write of one index returns the OLD entry.
//  FSM:
//   RUN   -> FLUSH on mispredict; load cnt=FLUSH_CYCLES-1.
//   FLUSH -> flush=1, predictions suppressed (sequential fetch), cnt decrements each cycle (also while stalled).
//            At cnt==0 and no mispredict -> RUN.
//            A mispredict while in FLUSH reloads cnt and redirects again.
//  flush is a registered FSM output: high exactly FLUSH_CYCLES cycles, starting the cycle after mispredict.
// CONFIGURATION
//  BTB_PERF_CNT_EN defined: adds outputs perf_branches[31:0] (upd_valid count) and perf_mispred[31:0]
//   (mispredict count). Both are saturating, reset to 0 and increment on posedge.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  bp_pkg: BTB entry typedef {valid, tag, target}, INSN_BYTES=4, FSM state enum {RUN, FLUSH}.
//  Sub-module btb_table: entry array with async read, sync write and async clear on rst.
//  btb_next_pc holds the PC register, the mispredict logic, the FSM and the optional counters.
// TESTING
//  Reset: assert rst mid-run with pc=0x40 -> pc=RESET_PC, btb_hit=0 and flush=0 immediately.
//  Sequential fetch: pred_taken=0 for 4 cycles from 0x0 -> pc 0x4, 0x8, 0xC, 0x10.
//  BTB learn: upd pc=0x10, taken, target=0x80, pred_taken=0 -> mispredict=1, pc=0x80 next cycle, flush high 2 cycles.
//   After returning to 0x10 with pred_taken=1 -> btb_hit=1 and next pc=0x80.
//  Target mispredict: upd taken=1, pred_taken=1, pred_target=0x80, target=0x90 -> pc=0x90; entry now holds 0x90.
//  Redirect beats stall: stall=1 with a not-taken mispredict at upd_pc=0x20 -> pc=0x24 next cycle.
//  Back-to-back: a second mispredict during cycle 1 of FLUSH -> counter reloads, flush high 2 more cycles.
//   With BTB_PERF_CNT_EN, perf_mispred=2 afterwards.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch target buffer and next-PC logic.
// Holds the BTB entry layout, the instruction size and the flush FSM states.
package bp_pkg;

    localparam int INSN_BYTES = 4;

    // Tag field sized for the smallest possible index (BTB_IDX_BITS = 0);
    // narrower tags are stored zero-extended.
    localparam int TAG_W = 30;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: asynchronous read, synchronous write and
// asynchronous clear on rst. A read of the index being written in the same
// cycle returns the entry as it was before the write.
import bp_pkg::*;

module btb_table #(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output btb_entry_t          rd_entry,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  btb_entry_t          wr_entry
);

    localparam int DEPTH = 1 << IDX_BITS;

    btb_entry_t entries [DEPTH];

    assign rd_entry = entries[rd_idx];

    // Entry array: cleared on reset, written when a taken branch resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/btb_next_pc.sv
// Fetch-stage next-PC generator. Combines the gshare taken prediction with a
// direct-mapped BTB target, resolves EX/MEM branch outcomes, trains the BTB,
// detects mispredicts and holds flush high for FLUSH_CYCLES after a redirect.
// Optional feature: define BTB_PERF_CNT_EN to add saturating perf counters
// (perf_branches, perf_mispred).
import bp_pkg::*;

module btb_next_pc #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BTB_IDX_BITS = 6,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic [31:0] pc,
    output logic        btb_hit,
    output logic [31:0] pred_target,
    output logic        flush,
    output logic        mispredict
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
`endif
);

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
        return TAG_W'(addr >> (BTB_IDX_BITS + 2));
    endfunction

    fsm_state_t        state;
    fsm_state_t        state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic [31:0]       next_pc;
    logic [31:0]       fix_pc;
    btb_entry_t        rd_entry;
    btb_entry_t        wr_entry;
    logic              btb_wr;

    btb_table #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc[BTB_IDX_BITS+1:2]),
        .rd_entry (rd_entry),
        .wr_en    (btb_wr),
        .wr_idx   (upd_pc[BTB_IDX_BITS+1:2]),
        .wr_entry (wr_entry)
    );

    assign btb_hit     = rd_entry.valid && (rd_entry.tag == tag_of(pc));
    assign pred_target = btb_hit ? rd_entry.target : 32'h0;

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));
    assign fix_pc     = upd_taken ? upd_target : upd_pc + 32'(INSN_BYTES);

    assign btb_wr          = upd_valid && upd_taken;
    assign wr_entry.valid  = 1'b1;
    assign wr_entry.tag    = tag_of(upd_pc);
    assign wr_entry.target = upd_target;

    // Next-PC priority: redirect, then stall, then predicted-taken BTB hit
    // (only outside a flush window), then sequential fetch.
    always_comb begin
        next_pc = pc + 32'(INSN_BYTES);
        if (mispredict) begin
            next_pc = fix_pc;
        end else if (stall) begin
            next_pc = pc;
        end else if (state == RUN && pred_taken && btb_hit) begin
            next_pc = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Flush FSM state and down-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Flush FSM next state: any mispredict (re)starts the window; the counter
    // keeps running while stalled.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (mispredict) begin
            state_next = FLUSH;
            cnt_next   = 4'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH) begin
            if (cnt == 4'd0) begin
                state_next = RUN;
            end else begin
                cnt_next = cnt - 4'd1;
            end
        end
    end

    // Flush FSM output: flush follows the registered state.
    always_comb begin
        flush = (state == FLUSH);
    end

`ifdef BTB_PERF_CNT_EN
    // Saturating counters of resolved branches and of mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches <= 32'h0;
            perf_mispred  <= 32'h0;
        end else begin
            if (upd_valid && perf_branches != 32'hFFFF_FFFF) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (mispredict && perf_mispred != 32'hFFFF_FFFF) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench for btb_next_pc: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch/BTB/flush rules.
// Build with BTB_PERF_CNT_EN defined to also check the perf counters.
module tb_btb_next_pc;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IDX_BITS = 6;
    localparam int          ENTRIES  = 64;
    localparam int          FC       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic [31:0] pc;
    logic        btb_hit;
    logic [31:0] pred_target;
    logic        flush;
    logic        mispredict;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_flush_left;
    longint      m_branches;
    longint      m_mispred;

    btb_next_pc #(
        .RESET_PC     (RESET_PC),
        .BTB_IDX_BITS (IDX_BITS),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .pred_taken      (pred_taken),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .pc              (pc),
        .btb_hit         (btb_hit),
        .pred_target     (pred_target),
        .flush           (flush),
        .mispredict      (mispredict)
`ifdef BTB_PERF_CNT_EN
        ,
        .perf_branches   (perf_branches),
        .perf_mispred    (perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    function automatic int m_index(input logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit();
        return m_valid[m_index(m_pc)] && (m_tag[m_index(m_pc)] == m_tagof(m_pc));
    endfunction

    function automatic logic [31:0] m_ptarget();
        return m_hit() ? m_tgt[m_index(m_pc)] : 32'h0;
    endfunction

    function automatic bit m_misp();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_pred_target != upd_target);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
        end
        m_flush_left = 0;
        m_branches   = 0;
        m_mispred    = 0;
    endtask

    task automatic idle();
        stall           = 1'b0;
        pred_taken      = 1'b0;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
    endtask

    task automatic drive_upd(input logic [31:0] p, input bit tk, input logic [31:0] tgt,
                             input bit ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = p;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic tick();
        bit          misp;
        logic [31:0] npc;
        misp = m_misp();
        if (misp) npc = upd_taken ? upd_target : upd_pc + 32'd4;
        else if (stall) npc = m_pc;
        else if (m_flush_left == 0 && pred_taken && m_hit()) npc = m_ptarget();
        else npc = m_pc + 32'd4;
        if (upd_valid && upd_taken) begin
            m_valid[m_index(upd_pc)] = 1'b1;
            m_tag[m_index(upd_pc)]   = m_tagof(upd_pc);
            m_tgt[m_index(upd_pc)]   = upd_target;
        end
        if (upd_valid && m_branches < 64'hFFFF_FFFF) m_branches++;
        if (misp && m_mispred < 64'hFFFF_FFFF) m_mispred++;
        if (misp) m_flush_left = FC;
        else if (m_flush_left > 0) m_flush_left--;
        @(posedge clk);
        #1;
        m_pc = npc;
    endtask

    // Redirect fetch to addr with a not-taken mispredict, then let the flush drain.
    task automatic goto_pc(input logic [31:0] addr);
        idle();
        drive_upd(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        idle();
        stall = 1'b1;
        repeat (FC) tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc !== RESET_PC) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC);
        end
        checks++;
        if (flush !== 1'b0 || btb_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: flush=%b btb_hit=%b expected 0/0", flush, btb_hit);
        end
        rst = 1'b0;
        // Redirect to 0x40 and train an entry for 0x40 so btb_hit and flush are high
        drive_upd(32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        #1;
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup_misp: got %b expected 1", mispredict);
        end
        tick();
        idle();
        #1;
        checks++;
        if (pc !== 32'h40 || btb_hit !== 1'b1 || flush !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: pc=%h hit=%b flush=%b expected 00000040/1/1", pc, btb_hit, flush);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== RESET_PC || btb_hit !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: pc=%h hit=%b flush=%b expected %h/0/0", pc, btb_hit, flush, RESET_PC);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'h4;
        exp_seq[1] = 32'h8;
        exp_seq[2] = 32'hC;
        exp_seq[3] = 32'h10;
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc !== exp_seq[i] || flush !== 1'b0) begin
                errors++;
                $display("FAIL seq_pc[%0d]: pc=%h flush=%b expected %h/0", i, pc, flush, exp_seq[i]);
            end
        end
    endtask

    task automatic test_btb_learn();
        drive_upd(32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL learn_misp: got %b expected 1", mispredict);
        end
        tick();
        idle();
        checks++;
        if (pc !== 32'h80 || flush !== 1'b1) begin
            errors++;
            $display("FAIL learn_redirect: pc=%h flush=%b expected 00000080/1", pc, flush);
        end
        tick();
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL learn_flush2: got %b expected 1", flush);
        end
        tick();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL learn_flush_end: got %b expected 0", flush);
        end
        goto_pc(32'h10);
        pred_taken = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h10 || btb_hit !== 1'b1 || pred_target !== 32'h80) begin
            errors++;
            $display("FAIL learn_hit: pc=%h hit=%b target=%h expected 00000010/1/00000080", pc, btb_hit, pred_target);
        end
        tick();
        idle();
        checks++;
        if (pc !== 32'h80) begin
            errors++;
            $display("FAIL learn_pred_pc: got %h expected 00000080", pc);
        end
    endtask

    task automatic test_target_mispredict();
        drive_upd(32'h10, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL tgt_misp: got %b expected 1", mispredict);
        end
        tick();
        idle();
        checks++;
        if (pc !== 32'h90) begin
            errors++;
            $display("FAIL tgt_pc: got %h expected 00000090", pc);
        end
        goto_pc(32'h10);
        #1;
        checks++;
        if (btb_hit !== 1'b1 || pred_target !== 32'h90) begin
            errors++;
            $display("FAIL tgt_entry: hit=%b target=%h expected 1/00000090", btb_hit, pred_target);
        end
    endtask

    task automatic test_redirect_stall();
        idle();
        stall = 1'b1;
        drive_upd(32'h20, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        idle();
        checks++;
        if (pc !== 32'h24 || flush !== 1'b1) begin
            errors++;
            $display("FAIL stall_redirect: pc=%h flush=%b expected 00000024/1", pc, flush);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        idle();
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        idle();
        checks++;
        if (pc !== 32'h200 || flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: pc=%h flush=%b expected 00000200/1", pc, flush);
        end
        drive_upd(32'h200, 1'b0, 32'h0, 1'b1, 32'h0);
        #1;
        checks++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL b2b_misp2: got %b expected 1", mispredict);
        end
        tick();
        idle();
        checks++;
        if (pc !== 32'h204 || flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: pc=%h flush=%b expected 00000204/1", pc, flush);
        end
        tick();
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_extend: got %b expected 1", flush);
        end
        tick();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got %b expected 0", flush);
        end
`ifdef BTB_PERF_CNT_EN
        checks++;
        if (perf_mispred !== 32'd2 || perf_branches !== 32'd2) begin
            errors++;
            $display("FAIL b2b_perf: mispred=%0d branches=%0d expected 2/2", perf_mispred, perf_branches);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            stall      = ($urandom_range(0, 3) == 0);
            pred_taken = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) begin
                upd_valid       = 1'b1;
                upd_pc          = 32'($urandom_range(0, 1023)) * 32'd4;
                upd_taken       = $urandom_range(0, 1) == 1;
                upd_target      = 32'($urandom_range(0, 255)) * 32'd4;
                upd_pred_taken  = $urandom_range(0, 1) == 1;
                upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target
                                  : 32'($urandom_range(0, 255)) * 32'd4;
            end
            #1;
            checks++;
            if (mispredict !== m_misp() || btb_hit !== m_hit() || pred_target !== m_ptarget()) begin
                errors++;
                $display("FAIL rand_comb[%0d]: misp=%b hit=%b tgt=%h expected %b/%b/%h",
                         n, mispredict, btb_hit, pred_target, m_misp(), m_hit(), m_ptarget());
            end
            tick();
            checks++;
            if (pc !== m_pc || flush !== (m_flush_left > 0)) begin
                errors++;
                $display("FAIL rand_state[%0d]: pc=%h flush=%b expected %h/%b",
                         n, pc, flush, m_pc, m_flush_left > 0);
            end
`ifdef BTB_PERF_CNT_EN
            checks++;
            if (perf_branches !== 32'(m_branches) || perf_mispred !== 32'(m_mispred)) begin
                errors++;
                $display("FAIL rand_perf[%0d]: branches=%0d mispred=%0d expected %0d/%0d",
                         n, perf_branches, perf_mispred, m_branches, m_mispred);
            end
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_btb_learn();
        test_target_mispredict();
        test_redirect_stall();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
